// File: rtl/dcom_feeder_pkg.sv
// Shared types and constants for the DCOM buffer feeder copy engine.
// The FSM enum and default geometry are used by the RTL and the bench.
package dcom_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR      = 2'd3
  } state_e;

  localparam int BUF_AW_DEF = 12;
  localparam int DATA_W_DEF = 64;

  localparam int unsigned MAX_LEN_DEF = 1 << BUF_AW_DEF;

  function automatic int unsigned max_len(input int buf_aw);
    return 1 << buf_aw;
  endfunction

endpackage

// File: rtl/dcom_buffer_feeder.sv
// Copies N 64-bit words from DDR2 (Avalon-MM read master) into the DCOM data
// buffer at word addresses 0..N-1 (Avalon-MM write master), one read in flight.
module dcom_buffer_feeder
  import dcom_feeder_pkg::*;
#(
  parameter int MEM_AW         = 32,
  parameter int BUF_AW         = BUF_AW_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk50_clk,
  input  logic                rst_reset_n,
  input  logic                cmd_start_i,
  input  logic [MEM_AW-1:0]   cmd_src_addr_i,
  input  logic [BUF_AW:0]     cmd_length_i,
  input  logic                cmd_abort_i,
  output logic                stat_busy_o,
  output logic                stat_done_o,
  output logic                stat_error_o,
  output logic [BUF_AW:0]     stat_words_o,
  output logic [MEM_AW-1:0]   mem_address_o,
  output logic                mem_read_o,
  input  logic [DATA_W-1:0]   mem_readdata_i,
  input  logic                mem_readdatavalid_i,
  input  logic                mem_waitrequest_i,
  output logic [BUF_AW-1:0]   buf_address_o,
  output logic                buf_write_o,
  output logic [DATA_W-1:0]   buf_writedata_o,
  output logic [DATA_W/8-1:0] buf_byteenable_o,
  input  logic                buf_waitrequest_i
);

  localparam int LEN_W = BUF_AW + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(max_len(BUF_AW));
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [BUF_AW-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TO_W-1:0]     timeout_q, timeout_d;
  logic                abort_pend_q, abort_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                start_legal;
  logic                abort_req;
  logic [TO_W-1:0]     timeout_inc;

  assign start_legal = (cmd_length_i != '0) && (cmd_length_i <= MAX_LEN) &&
                       (cmd_src_addr_i[2:0] == 3'b000);
  assign abort_req   = abort_pend_q | cmd_abort_i;
  assign timeout_inc = timeout_q + TO_W'(1);

  always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An accepted read always waits for its data, even under abort, so a stale
  // readdatavalid can never land in a later transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_start_i && start_legal) state_d = RD_REQ;
      RD_REQ:  if (!mem_waitrequest_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_readdatavalid_i)        state_d = abort_req ? IDLE : WR;
        else if (timeout_inc == TO_LIMIT) state_d = IDLE;
      end
      WR:      if (!buf_waitrequest_i)
                 state_d = ((remaining_q == LEN_W'(1)) || abort_req) ? IDLE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    words_d      = words_q;
    data_d       = data_q;
    timeout_d    = timeout_q;
    abort_pend_d = abort_req;
    error_d      = error_q;
    done_d       = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (cmd_start_i) begin
          if (start_legal) begin
            addr_d      = cmd_src_addr_i;
            remaining_d = cmd_length_i;
            idx_d       = '0;
            words_d     = '0;
            error_d     = 1'b0;
          end else begin
            error_d     = 1'b1;
          end
        end
      end
      RD_REQ: if (!mem_waitrequest_i) timeout_d = '0;
      RD_WAIT: begin
        if (mem_readdatavalid_i) begin
          if (!abort_req) data_d = mem_readdata_i;
        end else begin
          timeout_d = timeout_inc;
          if (timeout_inc == TO_LIMIT) error_d = 1'b1;
        end
      end
      WR: begin
        if (!buf_waitrequest_i) begin
          words_d     = words_q + LEN_W'(1);
          idx_d       = idx_q + BUF_AW'(1);
          addr_d      = addr_q + MEM_AW'(8);
          remaining_d = remaining_q - LEN_W'(1);
          done_d      = (remaining_q == LEN_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      words_q      <= '0;
      data_q       <= '0;
      timeout_q    <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      words_q      <= words_d;
      data_q       <= data_d;
      timeout_q    <= timeout_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    mem_read_o       = (state_q == RD_REQ);
    mem_address_o    = addr_q;
    buf_write_o      = (state_q == WR);
    buf_address_o    = idx_q;
    buf_writedata_o  = data_q;
    buf_byteenable_o = '1;
    stat_busy_o      = busy_q;
    stat_done_o      = done_q;
    stat_error_o     = error_q;
    stat_words_o     = words_q;
  end

endmodule

// File: tb/tb_dcom_buffer_feeder.sv
// Directed bench for dcom_buffer_feeder: a table of transfers run against
// simple Avalon slave models, plus hand-written timeout and reset sequences.
module tb_dcom_buffer_feeder;

  logic        clk50_clk = 1'b0;
  logic        rst_reset_n = 1'b0;
  logic        cmd_start_i = 1'b0;
  logic [31:0] cmd_src_addr_i = '0;
  logic [12:0] cmd_length_i = '0;
  logic        cmd_abort_i = 1'b0;
  logic        stat_busy_o, stat_done_o, stat_error_o;
  logic [12:0] stat_words_o;
  logic [31:0] mem_address_o;
  logic        mem_read_o;
  logic [63:0] mem_readdata_i = '0;
  logic        mem_readdatavalid_i = 1'b0;
  logic        mem_waitrequest_i = 1'b0;
  logic [11:0] buf_address_o;
  logic        buf_write_o;
  logic [63:0] buf_writedata_o;
  logic [7:0]  buf_byteenable_o;
  logic        buf_waitrequest_i = 1'b0;

  always #10 clk50_clk = ~clk50_clk;

  dcom_buffer_feeder dut (
    .clk50_clk           (clk50_clk),
    .rst_reset_n         (rst_reset_n),
    .cmd_start_i         (cmd_start_i),
    .cmd_src_addr_i      (cmd_src_addr_i),
    .cmd_length_i        (cmd_length_i),
    .cmd_abort_i         (cmd_abort_i),
    .stat_busy_o         (stat_busy_o),
    .stat_done_o         (stat_done_o),
    .stat_error_o        (stat_error_o),
    .stat_words_o        (stat_words_o),
    .mem_address_o       (mem_address_o),
    .mem_read_o          (mem_read_o),
    .mem_readdata_i      (mem_readdata_i),
    .mem_readdatavalid_i (mem_readdatavalid_i),
    .mem_waitrequest_i   (mem_waitrequest_i),
    .buf_address_o       (buf_address_o),
    .buf_write_o         (buf_write_o),
    .buf_writedata_o     (buf_writedata_o),
    .buf_byteenable_o    (buf_byteenable_o),
    .buf_waitrequest_i   (buf_waitrequest_i)
  );

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [12:0] len;
    int          mwait;
    int          bwait;
    int          abort_word;
    bit          no_rdv;
    bit          exp_busy;
    bit          exp_err;
    int          exp_reads;
    int          exp_writes;
    int          exp_done;
    logic [12:0] exp_words;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  int          r_reads, r_writes, r_done, r_accept_iter, r_end_iter;
  bit          r_busy_seen;
  logic [11:0] r_last_baddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory word at byte address a: word k above 0x1000 reads 0xA5A5_0000_0000_000k.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'h1000) >> 3;
    return 64'hA5A5_0000_0000_0000 | {32'h0, off};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   64'(stat_busy_o),      64'd0);
    check({tag, "_done"},   64'(stat_done_o),      64'd0);
    check({tag, "_error"},  64'(stat_error_o),     64'd0);
    check({tag, "_words"},  64'(stat_words_o),     64'd0);
    check({tag, "_maddr"},  64'(mem_address_o),    64'd0);
    check({tag, "_mread"},  64'(mem_read_o),       64'd0);
    check({tag, "_baddr"},  64'(buf_address_o),    64'd0);
    check({tag, "_bwrite"}, 64'(buf_write_o),      64'd0);
    check({tag, "_bdata"},  buf_writedata_o,       64'd0);
    check({tag, "_byteen"}, 64'(buf_byteenable_o), 64'hFF);
  endtask

  task automatic run_vec(input vec_t v, input int budget);
    int          iter, mstall, bstall;
    bit          rdv_sched, mprev_stall, bprev_stall, abort_sent;
    logic [31:0] rd_addr_acc, mprev_addr;
    logic [11:0] bprev_addr;
    logic [63:0] bprev_data;
    r_reads = 0; r_writes = 0; r_done = 0; r_busy_seen = 0;
    r_accept_iter = -1; r_end_iter = 0; r_last_baddr = '0;
    mstall = 0; bstall = 0; rdv_sched = 0; mprev_stall = 0; bprev_stall = 0;
    abort_sent = 0; rd_addr_acc = '0; mprev_addr = '0; bprev_addr = '0; bprev_data = '0;
    @(negedge clk50_clk);
    cmd_src_addr_i = v.src;
    cmd_length_i   = v.len;
    cmd_start_i    = 1'b1;
    @(negedge clk50_clk);
    cmd_start_i = 1'b0;
    iter = 0;
    forever begin
      if (stat_busy_o) r_busy_seen = 1;
      if (stat_done_o) r_done++;
      if (mprev_stall) begin
        check("mem_read_held", 64'(mem_read_o), 64'd1);
        check("mem_addr_held", 64'(mem_address_o), 64'(mprev_addr));
      end
      if (bprev_stall) begin
        check("buf_write_held", 64'(buf_write_o), 64'd1);
        check("buf_addr_held", 64'(buf_address_o), 64'(bprev_addr));
        check("buf_data_held", buf_writedata_o, bprev_data);
      end
      if (!stat_busy_o) begin
        check("bus_idle_at_end", {62'd0, mem_read_o, buf_write_o}, 64'd0);
        break;
      end
      mem_readdatavalid_i = 1'b0;
      mem_readdata_i      = '0;
      if (rdv_sched && !v.no_rdv) begin
        mem_readdatavalid_i = 1'b1;
        mem_readdata_i      = mem_word(rd_addr_acc);
      end
      rdv_sched = 0;
      mprev_stall = 0;
      mem_waitrequest_i = 1'b0;
      if (mem_read_o) begin
        if (mstall < v.mwait) begin
          mem_waitrequest_i = 1'b1;
          mstall++;
          mprev_stall = 1;
          mprev_addr  = mem_address_o;
        end else begin
          mstall = 0;
          check("rd_addr", 64'(mem_address_o), 64'(v.src + 32'(8 * r_reads)));
          rd_addr_acc = mem_address_o;
          r_reads++;
          rdv_sched = 1;
          if (r_accept_iter < 0) r_accept_iter = iter;
        end
      end
      bprev_stall = 0;
      buf_waitrequest_i = 1'b0;
      cmd_abort_i = 1'b0;
      if (buf_write_o) begin
        if (bstall < v.bwait) begin
          buf_waitrequest_i = 1'b1;
          bstall++;
          bprev_stall = 1;
          bprev_addr  = buf_address_o;
          bprev_data  = buf_writedata_o;
          if (r_writes == v.abort_word && !abort_sent) begin
            cmd_abort_i = 1'b1;
            abort_sent  = 1;
          end
        end else begin
          bstall = 0;
          check("wr_addr", 64'(buf_address_o), 64'(r_writes % 4096));
          check("wr_data", buf_writedata_o, mem_word(v.src + 32'(8 * r_writes)));
          r_last_baddr = buf_address_o;
          r_writes++;
        end
      end
      @(negedge clk50_clk);
      iter++;
      if (iter > budget) begin
        check({v.name, "_cycle_budget"}, 64'(iter), 64'(budget));
        break;
      end
    end
    r_end_iter = iter;
    mem_readdatavalid_i = 1'b0;
    mem_waitrequest_i   = 1'b0;
    buf_waitrequest_i   = 1'b0;
    cmd_abort_i         = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"basic",          32'h1000, 13'd4,    0, 0, -1, 0, 1, 0, 4,    4,    1, 13'd4};
    vecs[1] = '{"backpressure",   32'h2000, 13'd3,    5, 7, -1, 0, 1, 0, 3,    3,    1, 13'd3};
    vecs[2] = '{"full_buffer",    32'h0,    13'd4096, 0, 0, -1, 0, 1, 0, 4096, 4096, 1, 13'd4096};
    vecs[3] = '{"illegal_len0",   32'h1000, 13'd0,    0, 0, -1, 0, 0, 1, 0,    0,    0, 13'd4096};
    vecs[4] = '{"illegal_len4097",32'h1000, 13'd4097, 0, 0, -1, 0, 0, 1, 0,    0,    0, 13'd4096};
    vecs[5] = '{"illegal_src",    32'h1004, 13'd4,    0, 0, -1, 0, 0, 1, 0,    0,    0, 13'd4096};
    vecs[6] = '{"legal_after",    32'h5000, 13'd1,    0, 0, -1, 0, 1, 0, 1,    1,    1, 13'd1};
    vecs[7] = '{"abort",          32'h6000, 13'd10,   0, 3,  2, 0, 1, 0, 3,    3,    0, 13'd3};
    vecs[8] = '{"timeout",        32'h7000, 13'd2,    0, 0, -1, 1, 1, 1, 1,    0,    0, 13'd0};

    rst_reset_n = 1'b0;
    repeat (3) @(posedge clk50_clk);
    @(negedge clk50_clk);
    check_reset_outputs("reset");
    rst_reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], int'(vecs[i].len) * (6 + vecs[i].mwait + vecs[i].bwait) + 1200);
      check({vecs[i].name, "_busy_seen"}, 64'(r_busy_seen), 64'(vecs[i].exp_busy));
      check({vecs[i].name, "_reads"},     64'(r_reads),     64'(vecs[i].exp_reads));
      check({vecs[i].name, "_writes"},    64'(r_writes),    64'(vecs[i].exp_writes));
      check({vecs[i].name, "_done"},      64'(r_done),      64'(vecs[i].exp_done));
      check({vecs[i].name, "_words"},     64'(stat_words_o), 64'(vecs[i].exp_words));
      check({vecs[i].name, "_error"},     64'(stat_error_o), 64'(vecs[i].exp_err));
      if (vecs[i].len == 13'd4096)
        check("full_last_addr", 64'(r_last_baddr), 64'hFFF);
      if (vecs[i].no_rdv)
        check("timeout_cycles", 64'(r_end_iter - r_accept_iter), 64'd1025);
      $display("vec %0d %s: reads=%0d writes=%0d done=%0d words=%0d error=%0d",
               i, vecs[i].name, r_reads, r_writes, r_done, stat_words_o, stat_error_o);
    end

    // Asynchronous reset while a write is stalled in WR.
    @(negedge clk50_clk);
    cmd_src_addr_i = 32'h4000;
    cmd_length_i   = 13'd4;
    cmd_start_i    = 1'b1;
    buf_waitrequest_i = 1'b1;
    @(negedge clk50_clk);
    cmd_start_i = 1'b0;
    check("rst_seq_read", 64'(mem_read_o), 64'd1);
    @(negedge clk50_clk);
    mem_readdatavalid_i = 1'b1;
    mem_readdata_i      = mem_word(32'h4000);
    @(negedge clk50_clk);
    mem_readdatavalid_i = 1'b0;
    mem_readdata_i      = '0;
    check("rst_seq_in_wr",   64'(buf_write_o), 64'd1);
    check("rst_seq_wr_data", buf_writedata_o, mem_word(32'h4000));
    #5;
    rst_reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    $display("seq async_reset: busy=%0d write=%0d", stat_busy_o, buf_write_o);
    @(negedge clk50_clk);
    @(negedge clk50_clk);
    buf_waitrequest_i = 1'b0;
    rst_reset_n = 1'b1;

    run_vec(vecs[0], 200);
    check("post_reset_writes", 64'(r_writes), 64'd4);
    check("post_reset_done",   64'(r_done),   64'd1);
    check("post_reset_words",  64'(stat_words_o), 64'd4);
    $display("vec post_reset basic: reads=%0d writes=%0d done=%0d words=%0d",
             r_reads, r_writes, r_done, stat_words_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcom_buffer_feeder.md
Name: dcom_buffer_feeder

Overview:
- Avalon-MM copy engine directly upstream of the DCOM data buffer slave (12-bit word address, 64-bit data, 8-bit byteenable, waitrequest).
- On command, reads N 64-bit words from DDR2 over an Avalon-MM read master and writes them to buffer addresses 0..N-1 over an Avalon-MM write master.
- Reports busy, done and error to the NIOS-side control register block.

Parameters:
- MEM_AW, 32, byte address width of the DDR2 read master.
- BUF_AW, 12, word address width of the DCOM data buffer; capacity is 2**BUF_AW words.
- DATA_W, 64, data width of both masters; byteenable width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, maximum cycles from read acceptance to readdatavalid before an error abort.

Ports:
- clk50_clk  in  1  system clock; all logic in this single domain.
- rst_reset_n  in  1  asynchronous, active-low reset.
- cmd_start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- cmd_src_addr_i  in  MEM_AW  DDR2 byte start address; bits [2:0] must be 0.
- cmd_length_i  in  BUF_AW+1  word count, legal range 1..2**BUF_AW.
- cmd_abort_i  in  1  level/pulse abort request.
- stat_busy_o  out  1  high from accepted start until the return to IDLE.
- stat_done_o  out  1  one-cycle pulse on normal completion.
- stat_error_o  out  1  sticky; cleared by the next accepted start.
- stat_words_o  out  BUF_AW+1  count of words written in the current or last transfer.
- mem_address_o  out  MEM_AW  read byte address.
- mem_read_o  out  1  read request.
- mem_readdata_i  in  DATA_W  read data.
- mem_readdatavalid_i  in  1  read data valid.
- mem_waitrequest_i  in  1  read master stall.
- buf_address_o  out  BUF_AW  buffer word address.
- buf_write_o  out  1  write request.
- buf_writedata_o  out  DATA_W  write data.
- buf_byteenable_o  out  DATA_W/8  write byte enables; always all ones.
- buf_waitrequest_i  in  1  buffer slave stall.

Behaviour:
- Reset values: all outputs 0, except buf_byteenable_o = all ones. FSM in IDLE. All counters 0.
- IDLE:
  - cmd_start_i with a legal command (length 1..2**BUF_AW and src[2:0] = 0): latch the address, set remaining = length, clear word index, clear stat_words_o and stat_error_o, assert busy, go to RD_REQ.
  - cmd_start_i with an illegal command: set stat_error_o, stay in IDLE, busy stays low, no bus activity.
- RD_REQ:
  - mem_read_o = 1 and mem_address_o = current address.
  - Hold both stable while mem_waitrequest_i = 1.
  - When waitrequest is low, the read is accepted: drop mem_read_o next cycle, clear the timeout counter, go to RD_WAIT.
- RD_WAIT:
  - Increment the timeout counter each cycle.
  - On mem_readdatavalid_i: capture the data into the write register, go to WR.
  - Timeout counter reaching TIMEOUT_CYCLES: set stat_error_o, go to IDLE. No done pulse.
- WR:
  - buf_write_o = 1, buf_address_o = word index, buf_writedata_o = captured data.
  - Hold all three stable while buf_waitrequest_i = 1.
  - On acceptance:
    - increment stat_words_o and the word index, add 8 to the address, decrement remaining;
    - if remaining reaches 0: pulse stat_done_o, go to IDLE;
    - otherwise go to RD_REQ.
- Single outstanding read. Best-case throughput is 1 word per 3 cycles with zero-wait slaves.
- Abort:
  - cmd_abort_i is recorded in a pending flag and acted on only at a transaction boundary: in RD_REQ/WR after acceptance, in RD_WAIT after readdatavalid, with the data discarded.
  - It never drops a request held under waitrequest.
  - Completion by abort: go to IDLE, no done pulse, stat_error_o unchanged.
  - Abort in IDLE: ignored, and the pending flag is cleared.
- Boundaries:
  - length = 2**BUF_AW: the last write uses buf_address_o = 2**BUF_AW-1.
  - The word index never wraps within a transfer.
  - DDR2 address wrap past 2**MEM_AW is not checked; it wraps modulo 2**MEM_AW.
  - cmd_start_i while busy: ignored.
  - Spurious mem_readdatavalid_i outside RD_WAIT: ignored.
- busy deasserts in the same cycle that done pulses: both are registered and update on the same edge.

Decomposition:
- Shared package dcom_feeder_pkg holds:
  - FSM state enum (IDLE, RD_REQ, RD_WAIT, WR);
  - BUF_AW/DATA_W default constants;
  - a helper constant for the max length.
- The FSM, counters and registers live in one module.
- No sub-module is needed; the timeout counter is inline.

Test Plan:
- Basic copy: start src=0x0000_1000, len=4, zero-wait slaves, memory word k = 0xA5A5_0000_0000_000k.
  - Expect buffer writes to addresses 0..3 with matching data.
  - Expect read addresses 0x1000, 0x1008, 0x1010, 0x1018.
  - Expect done pulse once, stat_words_o = 4, busy low after.
- Backpressure: len=3, mem_waitrequest_i high 5 cycles per read, buf_waitrequest_i high 7 cycles per write.
  - Expect requests held stable throughout each stall.
  - Expect exactly 3 reads and 3 writes, and done.
- Full buffer: len=4096.
  - Expect 4096 writes, last at buf_address_o = 0xFFF.
  - Expect stat_words_o = 4096, no wrap.
- Illegal commands: len=0, then len=4097, then src=0x1004.
  - Each sets stat_error_o with no bus activity and busy staying low.
  - A following legal start clears stat_error_o.
- Abort during a stalled write (len=10, abort at word 2 while buf_waitrequest_i is high).
  - Expect the write for word 2 to complete on acceptance, then IDLE.
  - Expect stat_words_o = 3, no done pulse.
- Timeout and reset: readdatavalid withheld for 1024 cycles after read acceptance.
  - Expect stat_error_o set and a return to IDLE.
  - Then start a transfer and assert rst_reset_n low mid-WR: all outputs go to reset values asynchronously.
